mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
Two-port arbiter that shares the single synchronous memory (6-bit address, 16-bit data) between two requesters. Port 0 is the CPU; port 1 is the loader/debug/IO master.
Each request is a single read or write with a req/done handshake. The arbiter latches the command, sequences the memory access with its one-cycle read latency, and returns read data.
Round-robin priority prevents starvation. The arbiter sits between the requesters and the memory instance in the top level.

Parameters:
ADDR_WIDTH, 6, memory address width
DATA_WIDTH, 16, memory data width

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
req0  input  1  port 0 request; held high until done0
we0  input  1  port 0 command: 1=write, 0=read; stable while req0
addr0  input  ADDR_WIDTH  port 0 address; stable while req0
wdata0  input  DATA_WIDTH  port 0 write data; stable while req0
gnt0  output  1  port 0 owns memory (ACCESS..RESP)
done0  output  1  one-cycle completion pulse for port 0
rdata0  output  DATA_WIDTH  port 0 read data; valid with done0, held until next port 0 read completes
req1, we1, addr1, wdata1, gnt1, done1, rdata1  same as port 0, for port 1
mem_in  input  DATA_WIDTH  memory read data; valid the cycle after mem_addr is presented
mem_we  output  1  memory write enable; memory writes on the posedge where it is high
mem_addr  output  ADDR_WIDTH  memory address (registered)
mem_data  output  DATA_WIDTH  memory write data (registered)
busy  output  1  high in any state except IDLE

Behaviour:
- Reset values:
  - state = IDLE.
  - All outputs 0: mem_we, mem_addr, mem_data, gnt0/1, done0/1, rdata0/1, busy.
  - last_grant = 1, so port 0 wins the first tie.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - If no req, stay in IDLE.
  - Otherwise select a winner:
    - only one req high -> that port;
    - both high -> the port != last_grant.
  - At the clock edge, latch the winner's we/addr/wdata into cmd_we/mem_addr/mem_data, set owner and last_grant = winner, and go to ACCESS.
- ACCESS:
  - gnt[owner] = 1.
  - mem_we = cmd_we (combinational from the latched command, high only in ACCESS).
  - Write -> RESP. Read -> WAIT.
- WAIT (read only):
  - mem_in is valid this cycle.
  - At the edge, rdata[owner] <= mem_in; go to RESP.
- RESP:
  - done[owner] = 1 and gnt[owner] = 1 for exactly one cycle; next state IDLE.
- Latency, counting the IDLE cycle where req is first seen as cycle 0:
  - write: mem_we in cycle 1, done in cycle 2;
  - read: done in cycle 3, rdata valid in cycle 3.
  - Minimum issue period: 3 cycles per write, 4 per read.
- Handshake:
  - The requester deasserts req at the edge ending its done cycle, or keeps it high to issue a new command.
  - req still high in the following IDLE cycle counts as a new request and is arbitrated normally.
  - Round-robin therefore alternates under continuous contention.
- Non-owner isolation:
  - Changes on the non-owner's req/addr/data during a transaction have no effect.
  - A non-owner's req stays pending until IDLE.
  - The owner's inputs are ignored after latching.
- mem_addr and mem_data keep the last latched values while IDLE. mem_we is never high outside ACCESS.
- Only one of gnt0/gnt1 is ever high, and only one of done0/done1.
- rdata of the non-owner and rdata after a write are unchanged.
- Reset mid-operation: immediate return to reset values. No done is issued. An in-flight write is dropped if rst_n falls before the ACCESS edge.
- No address/data arithmetic; widths pass through unchanged.

Test Plan:
- Reset: assert rst_n=0 mid-ACCESS of a write -> mem_we=0, outputs 0, state IDLE; after release, a port 0 request wins the first tie.
- Port 0 write: req0=1, we0=1, addr0=6'h0A, wdata0=16'h1234 -> mem_we=1 with mem_addr=0A and mem_data=1234 in cycle 1; done0 pulse in cycle 2; memory[0A]=1234.
- Port 1 read: memory[0A]=1234; req1=1, we1=0, addr1=0A -> mem_addr=0A from cycle 1; done1 in cycle 3 with rdata1=1234; rdata0 unchanged.
- Contention: req0 and req1 held high continuously with reads of 01 and 02 -> grants alternate 0,1,0,1; each done matches its owner; no gnt overlap.
- Isolation: while port 0 owns a read of 05, change addr1 and wdata1 every cycle -> mem_addr stays 05 and mem_we stays 0 until done0; port 1 is then served with its value at sampling.
- Back-to-back from one port: req0 kept high across done0 with a new addr -> second access starts after exactly one IDLE cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single synchronous memory with
// one-cycle read latency; each port issues single read/write commands via req/done.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic                  gnt0,
    output logic                  done0,
    output logic [DATA_WIDTH-1:0] rdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt1,
    output logic                  done1,
    output logic [DATA_WIDTH-1:0] rdata1,
    input  logic [DATA_WIDTH-1:0] mem_in,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_owner;
    logic                  r_last_grant;
    logic                  r_cmd_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_data;
    logic [DATA_WIDTH-1:0] r_rdata0;
    logic [DATA_WIDTH-1:0] r_rdata1;
    logic                  r_gnt0;
    logic                  r_gnt1;
    logic                  r_done0;
    logic                  r_done1;
    logic                  r_mem_we;
    logic                  r_busy;

    logic                  w_any_req;
    logic                  w_winner;
    logic                  w_win_we;
    logic [ADDR_WIDTH-1:0] w_win_addr;
    logic [DATA_WIDTH-1:0] w_win_data;
    logic                  w_next_owner;

    // Winner select: a lone requester wins, a tie goes to the port that did not win last.
    always_comb begin
        w_any_req = req0 | req1;
        if (req0 && req1) begin
            w_winner = ~r_last_grant;
        end else if (req0) begin
            w_winner = 1'b0;
        end else begin
            w_winner = 1'b1;
        end
        if (w_winner) begin
            w_win_we   = we1;
            w_win_addr = addr1;
            w_win_data = wdata1;
        end else begin
            w_win_we   = we0;
            w_win_addr = addr0;
            w_win_data = wdata0;
        end
    end

    // Next-state and next-owner decode for the access sequencer.
    always_comb begin
        w_next_state = r_state;
        w_next_owner = r_owner;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_next_state = S_ACCESS;
                    w_next_owner = w_winner;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_ACCESS: begin
                if (r_cmd_we) begin
                    w_next_state = S_RESP;
                end else begin
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT:  w_next_state = S_RESP;
            S_RESP:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // State, command latch and read-data capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_cmd_we     <= 1'b0;
            r_mem_addr   <= {ADDR_WIDTH{1'b0}};
            r_mem_data   <= {DATA_WIDTH{1'b0}};
            r_rdata0     <= {DATA_WIDTH{1'b0}};
            r_rdata1     <= {DATA_WIDTH{1'b0}};
        end else begin
            r_state <= w_next_state;
            if ((r_state == S_IDLE) && w_any_req) begin
                r_owner      <= w_winner;
                r_last_grant <= w_winner;
                r_cmd_we     <= w_win_we;
                r_mem_addr   <= w_win_addr;
                r_mem_data   <= w_win_data;
            end
            if (r_state == S_WAIT) begin
                if (r_owner) begin
                    r_rdata1 <= mem_in;
                end else begin
                    r_rdata0 <= mem_in;
                end
            end
        end
    end

    // Status outputs are registered from the next-state decode so they line up with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt0   <= 1'b0;
            r_gnt1   <= 1'b0;
            r_done0  <= 1'b0;
            r_done1  <= 1'b0;
            r_mem_we <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_gnt0   <= (w_next_state != S_IDLE) && !w_next_owner;
            r_gnt1   <= (w_next_state != S_IDLE) && w_next_owner;
            r_done0  <= (w_next_state == S_RESP) && !w_next_owner;
            r_done1  <= (w_next_state == S_RESP) && w_next_owner;
            r_mem_we <= (w_next_state == S_ACCESS) && w_win_we;
            r_busy   <= (w_next_state != S_IDLE);
        end
    end

    assign gnt0     = r_gnt0;
    assign gnt1     = r_gnt1;
    assign done0    = r_done0;
    assign done1    = r_done1;
    assign rdata0   = r_rdata0;
    assign rdata1   = r_rdata1;
    assign mem_we   = r_mem_we;
    assign mem_addr = r_mem_addr;
    assign mem_data = r_mem_data;
    assign busy     = r_busy;

endmodule
